// File: rtl/pp_stream_pkg.sv
// Shared definitions for the ping-pong stream buffer: read FSM encoding,
// bank count, RAM sizing helper and drop-counter width.
package pp_stream_pkg;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    localparam int NUM_BANKS  = 2;
    localparam int DROP_CNT_W = 16;

    // Total RAM words for a given per-bank depth.
    function automatic int ram_depth(input int depth);
        return NUM_BANKS * depth;
    endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read output returns zero on any cycle the read port is not enabled.
module dp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dia,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] dob
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wea) mem[addra] <= dia;
    end

    // Registered read port, zero when idle
    always_ff @(posedge clk) begin
        dob <= enb ? mem[addrb] : '0;
    end

endmodule

// File: rtl/pp_stream_buf.sv
// Two-bank ping-pong stream buffer. The write side fills one bank while the
// read side drains the other; banks swap on frame completion.
// Optional build macro PP_DROP_CNT_EN: write side never stalls, words that
// arrive while the write bank is still full are dropped and counted.
//
// Read FSM states:
//   state     | meaning
//   RD_IDLE   | waiting for the read bank to be full; issues read of word 0
//   RD_PRIME  | first RAM word returning into the output register
//   RD_STREAM | words presented on rd_*, prefetch keeps 1 word/clk flowing
module pp_stream_buf
    import pp_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDRW      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [1:0]            bank_full,
    output logic [ADDRW:0]        frame_len
`ifdef PP_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int              RAM_DEPTH = ram_depth(DEPTH);
    localparam logic [ADDRW-1:0] LAST_PTR = ADDRW'(DEPTH - 1);
    localparam logic [ADDRW:0]   ONE      = (ADDRW+1)'(1);

    rd_state_t state, state_next;

    logic                  wr_bank, rd_bank;
    logic [ADDRW-1:0]      wr_ptr;
    logic [ADDRW:0]        rd_ptr;
    logic [ADDRW:0]        len_q [NUM_BANKS];
    logic                  wr_fire, wr_close, rd_release;
    logic [1:0]            full_set, full_clr;

    logic                  ram_en, start, step, start_bank;
    logic [ADDRW:0]        ram_addr;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  pend, pend_last;

    logic                  out_valid, out_last, skid_valid, skid_last;
    logic [DATA_WIDTH-1:0] out_data, skid_data;
    logic                  pop, remaining, credit_ok;
    logic [1:0]            occ_sum;

`ifdef PP_DROP_CNT_EN
    logic wr_drop;
    assign wr_ready = 1'b1;
    assign wr_fire  = wr_valid && !bank_full[wr_bank];
    assign wr_drop  = wr_valid && bank_full[wr_bank];

    // Saturating count of words lost to a full write bank
    always_ff @(posedge clk) begin
        if (rst)                                drop_cnt <= '0;
        else if (wr_drop && (drop_cnt != '1))   drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign wr_ready = !rst && !bank_full[wr_bank];
    assign wr_fire  = wr_valid && wr_ready;
`endif

    assign wr_close   = wr_fire && (wr_last || (wr_ptr == LAST_PTR));
    assign pop        = out_valid && rd_ready;
    assign rd_release = pop && out_last;
    assign remaining  = (rd_ptr != frame_len);
    // Words buffered or in flight; a new read is allowed only if it cannot
    // overflow the two output entries, counting this cycle's pop.
    assign occ_sum    = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, pend};
    assign credit_ok  = (occ_sum - {1'b0, pop}) < 2'd2;

    assign rd_valid = out_valid;
    assign rd_data  = out_data;
    assign rd_last  = out_valid && out_last;

    // Write pointer, bank select and per-bank frame length capture
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            wr_ptr   <= '0;
            len_q[0] <= '0;
            len_q[1] <= '0;
        end else if (wr_fire) begin
            if (wr_close) begin
                len_q[wr_bank] <= {1'b0, wr_ptr} + ONE;
                wr_bank        <= ~wr_bank;
                wr_ptr         <= '0;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Close and release can land on different banks in the same cycle
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (wr_close)   full_set[wr_bank] = 1'b1;
        if (rd_release) full_clr[rd_bank] = 1'b1;
    end

    // Bank full flags and read bank select
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            rd_bank   <= 1'b0;
        end else begin
            bank_full <= (bank_full & ~full_clr) | full_set;
            if (rd_release) rd_bank <= ~rd_bank;
        end
    end

    dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDRW + 1),
        .DEPTH      (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .wea   (wr_fire),
        .addra ({wr_bank, wr_ptr}),
        .dia   (wr_data),
        .enb   (ram_en),
        .addrb (ram_addr),
        .dob   (ram_dout)
    );

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= RD_IDLE;
        else     state <= state_next;
    end

    // Read FSM next state
    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE:   if (bank_full[rd_bank]) state_next = RD_PRIME;
            RD_PRIME:  state_next = RD_STREAM;
            RD_STREAM: if (rd_release) state_next = bank_full[!rd_bank] ? RD_PRIME : RD_IDLE;
            default:   state_next = RD_IDLE;
        endcase
    end

    // Read FSM outputs: RAM read issue (frame start or prefetch step)
    always_comb begin
        start      = 1'b0;
        start_bank = rd_bank;
        step       = 1'b0;
        case (state)
            RD_IDLE: begin
                if (bank_full[rd_bank]) start = 1'b1;
            end
            RD_PRIME: begin
                if (remaining && credit_ok) step = 1'b1;
            end
            RD_STREAM: begin
                if (rd_release && bank_full[!rd_bank]) begin
                    start      = 1'b1;
                    start_bank = !rd_bank;
                end else if (remaining && credit_ok) begin
                    step = 1'b1;
                end
            end
            default: ;
        endcase
        ram_en   = start || step;
        ram_addr = start ? {start_bank, {ADDRW{1'b0}}} : {rd_bank, rd_ptr[ADDRW-1:0]};
    end

    // Read pointer, frame length latch and in-flight read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            frame_len <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend <= ram_en;
            if (start) begin
                rd_ptr    <= ONE;
                frame_len <= len_q[start_bank];
                pend_last <= (len_q[start_bank] == ONE);
            end else if (step) begin
                rd_ptr    <= rd_ptr + ONE;
                pend_last <= (rd_ptr == frame_len - ONE);
            end
        end
    end

    // Output register plus skid entry; RAM data is captured the cycle it returns
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
        end else if (pop) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_last   <= skid_last;
                skid_valid <= pend;
                if (pend) begin
                    skid_data <= ram_dout;
                    skid_last <= pend_last;
                end
            end else begin
                out_valid <= pend;
                if (pend) begin
                    out_data <= ram_dout;
                    out_last <= pend_last;
                end
            end
        end else if (pend) begin
            if (out_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_dout;
                skid_last  <= pend_last;
            end else begin
                out_valid <= 1'b1;
                out_data  <= ram_dout;
                out_last  <= pend_last;
            end
        end
    end

endmodule

// File: tb/tb_pp_stream_buf.sv
// Self-checking bench for pp_stream_buf (DEPTH=16, DATA_WIDTH=32).
// Build with PP_DROP_CNT_EN defined to exercise the drop-counter variant.
module tb_pp_stream_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef PP_DROP_CNT_EN
    localparam bit DROP_MODE = 1'b1;
`else
    localparam bit DROP_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, wr_valid, wr_last, rd_ready;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_ready, rd_valid, rd_last;
    logic [1:0]    bank_full;
    logic [AW:0]   frame_len;
`ifdef PP_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    always #5 clk = ~clk;

    pp_stream_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .bank_full (bank_full),
        .frame_len (frame_len)
`ifdef PP_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          n;
        bit          use_last;
        logic [31:0] base;
        int          mode;      // 0: rd_ready held high, 1: toggles every cycle
        int          exp_len;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n words base..base+n-1; must be entered just after a rising edge.
    task automatic write_frame(input int n, input logic [31:0] base, input bit use_last);
        int nacc;
        nacc = 0;
        for (int i = 0; i < n; i++) begin
            int guard;
            bit acc;
            guard = 0;
            acc   = 1'b0;
            wr_valid = 1'b1;
            wr_data  = base + i;
            wr_last  = use_last && (i == n - 1);
            while (!acc && guard < 300) begin
                @(negedge clk);
                acc = wr_ready;
                tick();
                guard++;
            end
            if (acc) nacc++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        chk("wr_words", nacc, n);
    endtask

    // Drain n words and compare order, rd_last placement, frame_len and hold.
    task automatic read_frame(input int n, input logic [31:0] base, input int mode, input int exp_len);
        int            idx, guard;
        bit            hold, tog, lenchk;
        logic [DW-1:0] held;
        idx = 0; guard = 0; hold = 0; tog = 0; lenchk = 0; held = '0;
        while (idx < n && guard < 400) begin
            rd_ready = (mode == 0) ? 1'b1 : tog;
            tog = ~tog;
            @(negedge clk);
            if (hold) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_data", rd_data, held);
            end
            hold = 0;
            if (rd_valid) begin
                if (!lenchk) begin
                    chk("frame_len", frame_len, exp_len);
                    lenchk = 1;
                end
                if (rd_ready) begin
                    chk("rd_data", rd_data, base + idx);
                    chk("rd_last", rd_last, (idx == exp_len - 1));
                    idx++;
                end else begin
                    hold = 1;
                    held = rd_data;
                end
            end
            tick();
            guard++;
        end
        rd_ready = 1'b0;
        chk("rd_words", idx, n);
    endtask

    task automatic check_drained(input string tag);
        @(negedge clk);
        chk({tag, "_bank_full"}, bank_full, 2'b00);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16, 1'b0, 32'h0000_0010, 0, 16};
        vecs[1] = '{ 3, 1'b1, 32'h0000_00A0, 0,  3};
        vecs[2] = '{16, 1'b0, 32'h0000_0100, 1, 16};
        vecs[3] = '{ 1, 1'b1, 32'h0000_0055, 0,  1};
        vecs[4] = '{16, 1'b1, 32'h0000_0200, 1, 16};
        vecs[5] = '{ 5, 1'b1, 32'h0000_0250, 1,  5};

        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; rd_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, DROP_MODE);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_ready", wr_ready, 1);
        chk("post_rst_rd_valid", rd_valid, 0);
        chk("post_rst_rd_data", rd_data, 0);
        chk("post_rst_rd_last", rd_last, 0);
        chk("post_rst_bank_full", bank_full, 2'b00);
        chk("post_rst_frame_len", frame_len, 0);
        tick();

        // Full frame: first rd_valid two edges after bank_full sets
        write_frame(16, 32'h0, 1'b0);
        @(negedge clk);
        chk("lat_bank_full", bank_full, 2'b01);
        chk("lat_n0_rd_valid", rd_valid, 0);
        tick();
        @(negedge clk);
        chk("lat_n1_rd_valid", rd_valid, 0);
        tick();
        @(negedge clk);
        chk("lat_n2_rd_valid", rd_valid, 1);
        chk("lat_n2_rd_data", rd_data, 0);
        tick();
        read_frame(16, 32'h0, 0, 16);
        check_drained("full");

        for (int v = 0; v < 6; v++) begin
            write_frame(vecs[v].n, vecs[v].base, vecs[v].use_last);
            read_frame(vecs[v].exp_len, vecs[v].base, vecs[v].mode, vecs[v].exp_len);
            check_drained("vec");
        end

`ifndef PP_DROP_CNT_EN
        // Both banks full stalls the writer until one bank drains
        write_frame(32, 32'h300, 1'b0);
        @(negedge clk);
        chk("both_wr_ready", wr_ready, 0);
        chk("both_bank_full", bank_full, 2'b11);
        tick();
        read_frame(16, 32'h300, 0, 16);
        @(negedge clk);
        chk("release_wr_ready", wr_ready, 1);
        chk("release_one_full", $countones(bank_full), 1);
        tick();
        read_frame(16, 32'h310, 0, 16);
        check_drained("both");

        // Writer and reader running concurrently, including bank swap under load
        fork
            begin
                write_frame(16, 32'h400, 1'b0);
                write_frame(4, 32'h500, 1'b1);
                write_frame(16, 32'h600, 1'b0);
            end
            begin
                read_frame(16, 32'h400, 1, 16);
                read_frame(4, 32'h500, 0, 4);
                read_frame(16, 32'h600, 1, 16);
            end
        join
        check_drained("conc");
`endif

        // Reset in the middle of a frame discards it
        write_frame(7, 32'h700, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        begin
            bit seen_valid;
            bit seen_full;
            seen_valid = 0;
            seen_full  = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                seen_valid |= rd_valid;
                seen_full  |= (bank_full != 2'b00);
                tick();
            end
            chk("midrst_rd_valid", seen_valid, 0);
            chk("midrst_bank_full", seen_full, 0);
        end
        write_frame(16, 32'h800, 1'b0);
        read_frame(16, 32'h800, 0, 16);
        check_drained("midrst");

`ifdef PP_DROP_CNT_EN
        // Overflow words are dropped and counted; stored frames stay intact
        write_frame(32, 32'h900, 1'b0);
        write_frame(5, 32'hDEAD0, 1'b1);
        @(negedge clk);
        chk("drop_cnt", drop_cnt, 16'd5);
        chk("drop_bank_full", bank_full, 2'b11);
        chk("drop_wr_ready", wr_ready, 1);
        tick();
        read_frame(16, 32'h900, 0, 16);
        read_frame(16, 32'h910, 1, 16);
        check_drained("drop");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
